// File: rtl/lm_sm_sequencer_pkg.sv
// Shared types and widths for the LM/SM multiple-transfer sequencer.
package lm_sm_sequencer_pkg;
  localparam int WORD_W    = 16;
  localparam int REG_AW    = 3;
  localparam int LIST_W    = 8;
  localparam int ADDR_STEP = 2;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/lm_sm_sequencer_lsb_enc.sv
// Lowest-set-bit priority encoder: index of the lowest 1 in list_i, vld_o when any bit set.
module lsb_priority_enc
  import lm_sm_sequencer_pkg::*;
(
  input  logic [LIST_W-1:0] list_i,
  output logic [REG_AW-1:0] idx_o,
  output logic              vld_o
);
  always_comb begin
    idx_o = '0;
    vld_o = |list_i;
    // Descending scan so the lowest set bit wins the last assignment.
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list_i[i]) idx_o = REG_AW'(i);
    end
  end
endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks a register list, one register<->memory transfer per cycle.
module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [WORD_W-1:0] base_addr,
  input  logic              flush,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic [WORD_W-1:0] reg_rdata,
  output logic [REG_AW-1:0] reg_addr,
  output logic              reg_we,
  output logic [WORD_W-1:0] reg_wdata,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  xfer_count
);
  state_e            state_q, state_d;
  logic [LIST_W-1:0] list_q, list_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              load_q, load_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] idx;
  logic              idx_vld;
  logic              xfer_act;

  lsb_priority_enc u_enc (
    .list_i (list_q),
    .idx_o  (idx),
    .vld_o  (idx_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          list_d  = reg_list;
          addr_d  = base_addr;
          load_d  = is_load;
          cnt_d   = '0;
          state_d = (reg_list != '0) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          // Clear the lowest set bit; 16-bit wrap and bit0 fall out of the plain add.
          list_d  = list_q & (list_q - LIST_W'(1));
          addr_d  = addr_q + WORD_W'(ADDR_STEP);
          cnt_d   = cnt_q + CNT_W'(1);
          if (list_d == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    xfer_act   = (state_q == ST_XFER) && idx_vld && !flush;
    reg_we     = xfer_act && load_q;
    mem_re     = xfer_act && load_q;
    mem_we     = xfer_act && !load_q;
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    reg_addr   = idx;
    mem_addr   = addr_q;
    xfer_count = cnt_q;
  end

  assign reg_wdata = mem_rdata;
  assign mem_wdata = reg_rdata;
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer with hand-computed expectations.
module tb_lm_sm_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, is_load, flush;
  logic [7:0]  reg_list;
  logic [15:0] base_addr, mem_rdata, reg_rdata;
  logic [2:0]  reg_addr;
  logic        reg_we, mem_re, mem_we, busy, done;
  logic [15:0] reg_wdata, mem_addr, mem_wdata;
  logic [3:0]  xfer_count;

  int total = 0;
  int bad   = 0;

  lm_sm_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .reg_list(reg_list),
    .base_addr(base_addr), .flush(flush), .mem_rdata(mem_rdata), .reg_rdata(reg_rdata),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs changed afterwards settle before the #1 sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_xfer(input string tag, input logic lm, input logic [2:0] ra,
                          input logic [15:0] ma, input logic [3:0] cnt);
    settle();
    chk({tag, ".busy"}, busy, 1'b1);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".reg_we"}, reg_we, lm);
    chk({tag, ".mem_re"}, mem_re, lm);
    chk({tag, ".mem_we"}, mem_we, !lm);
    chk({tag, ".reg_addr"}, reg_addr, ra);
    chk({tag, ".mem_addr"}, mem_addr, ma);
    chk({tag, ".cnt"}, xfer_count, cnt);
  endtask

  task automatic chk_quiet(input string tag, input logic b, input logic d, input logic [3:0] cnt);
    settle();
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
    chk({tag, ".strobes"}, {reg_we, mem_re, mem_we}, 3'b000);
    chk({tag, ".cnt"}, xfer_count, cnt);
  endtask

  task automatic chk_reset(input string tag);
    chk_quiet(tag, 1'b0, 1'b0, 4'd0);
    chk({tag, ".reg_addr"}, reg_addr, 3'd0);
    chk({tag, ".mem_addr"}, mem_addr, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; flush = 1'b0;
    reg_list = 8'h00; base_addr = 16'h0000; mem_rdata = 16'h0000; reg_rdata = 16'h0000;
    tick(); tick();
    chk_reset("rst_hold");
    rst = 1'b0;
    tick();
    chk_reset("rst_after");

    // LM 0x25 @0x0100: R0, R2, R5 then done on the 4th cycle
    start = 1'b1; is_load = 1'b1; reg_list = 8'h25; base_addr = 16'h0100;
    chk_quiet("lm25_start", 1'b0, 1'b0, 4'd0);
    tick(); start = 1'b0; mem_rdata = 16'hBEEF;
    chk_xfer("lm25_x0", 1'b1, 3'd0, 16'h0100, 4'd0);
    chk("lm25_wdata", reg_wdata, 16'hBEEF);
    tick(); chk_xfer("lm25_x1", 1'b1, 3'd2, 16'h0102, 4'd1);
    tick(); chk_xfer("lm25_x2", 1'b1, 3'd5, 16'h0104, 4'd2);
    tick(); chk_quiet("lm25_done", 1'b1, 1'b1, 4'd3);
    tick(); chk_quiet("lm25_idle", 1'b0, 1'b0, 4'd3);

    // SM 0xFF @0xFFFC with wrap; stray starts in XFER and DONE ignored
    start = 1'b1; is_load = 1'b0; reg_list = 8'hFF; base_addr = 16'hFFFC;
    tick(); start = 1'b0; reg_rdata = 16'h1234;
    chk_xfer("smff_x0", 1'b0, 3'd0, 16'hFFFC, 4'd0);
    chk("smff_wdata", mem_wdata, 16'h1234);
    tick(); chk_xfer("smff_x1", 1'b0, 3'd1, 16'hFFFE, 4'd1);
    tick(); start = 1'b1; reg_list = 8'h01; base_addr = 16'h4000; is_load = 1'b1;
    chk_xfer("smff_x2", 1'b0, 3'd2, 16'h0000, 4'd2);
    tick(); start = 1'b0;
    chk_xfer("smff_x3", 1'b0, 3'd3, 16'h0002, 4'd3);
    tick(); chk_xfer("smff_x4", 1'b0, 3'd4, 16'h0004, 4'd4);
    tick(); chk_xfer("smff_x5", 1'b0, 3'd5, 16'h0006, 4'd5);
    tick(); chk_xfer("smff_x6", 1'b0, 3'd6, 16'h0008, 4'd6);
    tick(); chk_xfer("smff_x7", 1'b0, 3'd7, 16'h000A, 4'd7);
    tick(); start = 1'b1;
    chk_quiet("smff_done", 1'b1, 1'b1, 4'd8);
    tick(); start = 1'b0;
    chk_quiet("smff_idle", 1'b0, 1'b0, 4'd8);
    tick(); chk_quiet("done_start_ignored", 1'b0, 1'b0, 4'd8);

    // Odd base: bit0 carried through
    start = 1'b1; is_load = 1'b0; reg_list = 8'h03; base_addr = 16'h0101;
    tick(); start = 1'b0;
    chk_xfer("odd_x0", 1'b0, 3'd0, 16'h0101, 4'd0);
    tick(); chk_xfer("odd_x1", 1'b0, 3'd1, 16'h0103, 4'd1);
    tick(); chk_quiet("odd_done", 1'b1, 1'b1, 4'd2);
    tick();

    // Empty list: done next cycle, count cleared
    start = 1'b1; is_load = 1'b1; reg_list = 8'h00; base_addr = 16'h0500;
    tick(); start = 1'b0;
    chk_quiet("empty_done", 1'b1, 1'b1, 4'd0);
    tick(); chk_quiet("empty_idle", 1'b0, 1'b0, 4'd0);

    // LM 0xF0, flush on 2nd transfer: only R4 written, no done
    start = 1'b1; is_load = 1'b1; reg_list = 8'hF0; base_addr = 16'h0200;
    tick(); start = 1'b0;
    chk_xfer("fl_x0", 1'b1, 3'd4, 16'h0200, 4'd0);
    tick(); flush = 1'b1;
    chk_quiet("fl_cycle", 1'b1, 1'b0, 4'd1);
    tick(); flush = 1'b0;
    chk_quiet("fl_idle", 1'b0, 1'b0, 4'd1);
    tick(); chk_quiet("fl_nodone", 1'b0, 1'b0, 4'd1);

    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1; reg_list = 8'h01;
    tick(); start = 1'b0; flush = 1'b0;
    chk_quiet("fl_prio", 1'b0, 1'b0, 4'd1);

    // rst mid-sequence, then R7 LM restarts cleanly
    start = 1'b1; is_load = 1'b1; reg_list = 8'h81; base_addr = 16'h0010;
    tick(); start = 1'b0;
    chk_xfer("rs_x0", 1'b1, 3'd0, 16'h0010, 4'd0);
    rst = 1'b1;
    tick(); chk_reset("rs_abort");
    rst = 1'b0;
    tick(); chk_reset("rs_after");
    start = 1'b1; is_load = 1'b1; reg_list = 8'h80; base_addr = 16'h0300;
    tick(); start = 1'b0;
    chk_xfer("r7_x0", 1'b1, 3'd7, 16'h0300, 4'd0);
    tick(); chk_quiet("r7_done", 1'b1, 1'b1, 4'd1);
    tick(); chk_quiet("r7_idle", 1'b0, 1'b0, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
